// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// master drives fetch data and decode control; slave is the queue.
interface if_id_queue_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic        flush;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_misaligned;
    logic        dec_ready;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr, dec_misaligned
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr, dec_misaligned
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {pc, instr, misaligned}.
// Presents a NOP to decode while empty; flush drops all in-flight entries.
module if_id_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    if_id_queue_if.slave           q,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    assign q.fetch_ready = (cnt != CW'(DEPTH));
    assign q.dec_valid   = (cnt != '0);
    assign push          = q.fetch_valid & q.fetch_ready;
    assign pop           = q.dec_valid & q.dec_ready;
    assign count         = cnt;
    assign head          = mem[rd_ptr];

    always_comb begin
        q.dec_pc         = 32'h0;
        q.dec_instr      = NOP_INSTR;
        q.dec_misaligned = 1'b0;
        if (q.dec_valid) begin
            q.dec_pc         = head.pc;
            q.dec_instr      = head.instr;
            q.dec_misaligned = head.mis;
        end
    end

    // Entry storage carries no reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (!rst && !q.flush && push) begin
            mem[wr_ptr] <= '{
                pc:    q.fetch_pc,
                instr: q.fetch_instr,
                mis:   (q.fetch_pc[1:0] != 2'b00)
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            assert (cnt <= CW'(DEPTH));
            assert (!(pop && cnt == '0));
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue-based model tracks accepted
// fetches; a negedge monitor compares every DUT output against it.
module tb_if_id_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;
    int         checks   = 0;
    int         failures = 0;
    bit         seen     = 1'b0;
    ent_t       exp_q[$];

    if_id_queue_if bus();

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst   (rst),
        .q     (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Reference model: the queue contents at each edge, from the rules only.
    always @(posedge clk) begin
        bit   room;
        bit   take;
        ent_t e;
        seen = 1'b1;
        if (rst || bus.flush) begin
            exp_q.delete();
        end else begin
            room = (exp_q.size() < DEPTH);
            take = (exp_q.size() > 0) && bus.dec_ready;
            if (take) void'(exp_q.pop_front());
            if (bus.fetch_valid && room) begin
                e.pc    = bus.fetch_pc;
                e.instr = bus.fetch_instr;
                e.mis   = (bus.fetch_pc % 4) != 0;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (seen) begin
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("fetch_ready", 64'(bus.fetch_ready),
                64'(exp_q.size() != DEPTH));
            chk("dec_valid", 64'(bus.dec_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("dec_pc", 64'(bus.dec_pc), 64'(exp_q[0].pc));
                chk("dec_instr", 64'(bus.dec_instr), 64'(exp_q[0].instr));
                chk("dec_mis", 64'(bus.dec_misaligned), 64'(exp_q[0].mis));
            end else begin
                chk("dec_pc_empty", 64'(bus.dec_pc), 64'h0);
                chk("dec_instr_nop", 64'(bus.dec_instr), 64'(NOP));
                chk("dec_mis_empty", 64'(bus.dec_misaligned), 64'h0);
            end
        end
    end

    task automatic cyc(input logic fv, input logic [31:0] pc,
                       input logic fl, input logic dr, input logic r);
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        bus.fetch_instr = $urandom;
        bus.flush       = fl;
        bus.dec_ready   = dr;
        rst             = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.flush       = 1'b0;
        bus.dec_ready   = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 1);

        // Fill three, hold decode
        for (int i = 0; i < 3; i++) cyc(1, 32'(i * 4), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Fill to full, fifth push dropped, then drain
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 32'(i * 4), 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);

        // Steady stream with wrap
        for (int i = 0; i < 10; i++) cyc(1, 32'h100 + 32'(i * 4), 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Flush beats concurrent push and pop
        for (int i = 0; i < 3; i++) cyc(1, 32'(i * 4), 0, 0, 0);
        cyc(1, 32'h40, 1, 1, 0);
        cyc(1, 32'h80, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);

        // Misaligned flag
        cyc(1, 32'h102, 0, 0, 0);
        cyc(1, 32'h104, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Reset during push and pop
        cyc(1, 32'h200, 0, 0, 0);
        cyc(1, 32'h204, 0, 0, 0);
        cyc(1, 32'h208, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);

        // Random traffic
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            logic fv;
            fv = ($urandom_range(0, 9) < 7);
            cyc(fv, pc | 32'($urandom_range(0, 7) == 0 ? 2 : 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 49) == 0));
            if (fv) pc = pc + 4;
        end
        cyc(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
